// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: frame width, default bit timing and receiver FSM states.
package uart_receiver_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10417;  // 100 MHz / 9600 Bd

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial line in, byte stream out with valid/ready, status pulses.
interface uart_receiver_if;
  import uart_receiver_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rdata;
  logic                 rvalid;
  logic                 rready;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun;

  // Receiver side: consumes the serial line, produces the byte stream.
  modport master (
    input  rx, rready,
    output rdata, rvalid, rx_busy, frame_err, overrun
  );

  // Register block side: drives the line (in test) and drains bytes.
  modport slave (
    output rx, rready,
    input  rdata, rvalid, rx_busy, frame_err, overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO; the head entry is presented combinationally from the array.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in, so full is no obstacle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the array is reset too so rdata reads 0 out of reset; at this depth that is just a few flops.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: rx synchroniser, mid-bit sampling FSM and receive FIFO.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input logic             clk,
  input logic             reset,
  uart_receiver_if.master bus
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]           sync;
  logic                 rx_s;
  rx_state_e            state;
  rx_state_e            state_nxt;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 cnt_clr;
  logic                 sample;
  logic                 push;
  logic                 ferr_nxt;
  logic                 full;
  logic                 empty;
  logic                 frame_err_q;
  logic                 overrun_q;

  assign rx_s = sync[1];

  // Two-flop synchroniser; resets to the idle line level so no false start is seen.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments let sync[1] take the old sync[0], forming a real two-stage chain.
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], bus.rx};
  end

  // Next-state and per-cycle strobes of the receive FSM.
  always_comb begin
    // NOTE: every output gets a default here so no path leaves one unassigned and infers a latch.
    state_nxt = state;
    cnt_clr   = 1'b0;
    sample    = 1'b0;
    push      = 1'b0;
    ferr_nxt  = 1'b0;
    unique case (state)
      IDLE: if (!rx_s) begin
        state_nxt = START;
        cnt_clr   = 1'b1;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_clr   = 1'b1;
        state_nxt = rx_s ? IDLE : DATA;  // line back high at mid start bit: glitch
      end
      DATA: if (cnt == BIT_LAST) begin
        cnt_clr = 1'b1;
        sample  = 1'b1;
        if (bit_idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
      end
      STOP: if (cnt == BIT_LAST) begin
        cnt_clr = 1'b1;
        if (rx_s) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr_nxt  = 1'b1;
          state_nxt = WAIT_IDLE;  // a break must end before a new start is accepted
        end
      end
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, bit-timing counter, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr || state == IDLE || state == WAIT_IDLE) cnt <= '0;
      else                                                cnt <= cnt + 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (sample)    bit_idx <= bit_idx + 1'b1;
      if (sample) shreg[bit_idx] <= rx_s;
    end
  end

  // Status pulses, both raised the cycle after the stop-bit sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_nxt;
      overrun_q   <= push && full && !bus.rready;  // full implies non-empty, so rready alone means a pop
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .full  (full),
    .pop   (bus.rready),
    .dout  (bus.rdata),
    .empty (empty)
  );

  assign bus.rvalid    = !empty;
  assign bus.rx_busy   = (state != IDLE);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule
